// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, data SRAM request, bypass bus; EXE_DIV_EN adds the iterative divider
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    // one-hot op order: add sub slt sltu and nor or xor sll srl sra lui
    always_comb begin
        alu_result = '0;
        if (alu_op[0])  alu_result = alu_result | (alu_src1 + alu_src2);
        if (alu_op[1])  alu_result = alu_result | (alu_src1 - alu_src2);
        if (alu_op[2])  alu_result = alu_result | {31'b0, ($signed(alu_src1) < $signed(alu_src2))};
        if (alu_op[3])  alu_result = alu_result | {31'b0, (alu_src1 < alu_src2)};
        if (alu_op[4])  alu_result = alu_result | (alu_src1 & alu_src2);
        if (alu_op[5])  alu_result = alu_result | ~(alu_src1 | alu_src2);
        if (alu_op[6])  alu_result = alu_result | (alu_src1 | alu_src2);
        if (alu_op[7])  alu_result = alu_result | (alu_src1 ^ alu_src2);
        if (alu_op[8])  alu_result = alu_result | (alu_src1 << alu_src2[4:0]);
        if (alu_op[9])  alu_result = alu_result | (alu_src1 >> alu_src2[4:0]);
        if (alu_op[10]) alu_result = alu_result | $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
        if (alu_op[11]) alu_result = alu_result | alu_src2;
    end
endmodule

module exe_stage #(
    parameter int DS_TO_ES_BUS_WD = 152,
    parameter int ES_TO_MS_BUS_WD = 71
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [37:0]                es_to_ds_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);
    logic                       es_valid_q;
    logic [DS_TO_ES_BUS_WD-1:0] es_bus_q;
    logic                       es_ready_go;
    logic [3:0]                 div_op;
    logic [11:0]                alu_op;
    logic                       res_from_mem, mem_we, gr_we;
    logic [4:0]                 dest;
    logic [31:0]                src1, src2, st_data, pc;
    logic [31:0]                alu_result, es_result;

    assign {div_op, alu_op, res_from_mem, mem_we, gr_we, dest, src1, src2, st_data, pc} = es_bus_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         es_valid_q <= 1'b0;
        else if (es_allowin) es_valid_q <= ds_to_es_valid;
    end

    // payload intentionally unreset; es_valid_q qualifies it
    always_ff @(posedge clk) begin
        if (ds_to_es_valid && es_allowin) es_bus_q <= ds_to_es_bus;
    end

    alu u_alu (
        .alu_op     (alu_op),
        .alu_src1   (src1),
        .alu_src2   (src2),
        .alu_result (alu_result)
    );

`ifdef EXE_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [32:0] shifted, trial;
    logic        is_div, div_signed, q_neg, r_neg;
    logic [31:0] quo_fix, rem_fix;

    assign is_div     = |div_op;
    assign div_signed = div_op[3] | div_op[2];
    assign q_neg      = div_signed && (src1[31] ^ src2[31]);
    assign r_neg      = div_signed && src1[31];

    // quo_q holds the dividend being shifted out while quotient bits shift in
    assign shifted = {rem_q, quo_q[31]};
    assign trial   = shifted - {1'b0, dvs_q};

    assign quo_fix = (dvs_q == 32'd0) ? 32'hFFFF_FFFF : (q_neg ? -quo_q : quo_q);
    assign rem_fix = r_neg ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        case (state_q)
            S_IDLE: if (es_valid_q && is_div) begin
                state_d = S_BUSY;
                cnt_d   = '0;
                rem_d   = '0;
                quo_d   = (div_signed && src1[31]) ? -src1 : src1;
                dvs_d   = (div_signed && src2[31]) ? -src2 : src2;
            end
            S_BUSY: begin
                rem_d = trial[32] ? shifted[31:0] : trial[31:0];
                quo_d = {quo_q[30:0], ~trial[32]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_DONE;
            end
            S_DONE: if (es_to_ms_valid && ms_allowin) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign es_ready_go = !is_div || (state_q == S_DONE);
    assign es_result   = !is_div ? alu_result : ((div_op[3] | div_op[1]) ? quo_fix : rem_fix);
`else
    // div_op is a don't-care without the divider
    assign es_ready_go = 1'b1 | (&div_op);
    assign es_result   = alu_result;
`endif

    assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid_q && es_ready_go;
    assign es_to_ms_bus   = {res_from_mem, gr_we, dest, es_result, pc};
    assign es_to_ds_bus   = {es_valid_q && res_from_mem, (es_valid_q && gr_we) ? dest : 5'd0, es_result};

    assign data_sram_en    = es_valid_q && (res_from_mem || mem_we) && ms_allowin;
    assign data_sram_we    = {4{es_valid_q && mem_we && ms_allowin}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = st_data;
endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - randomized scoreboard bench for exe_stage
module tb_exe_stage;
    logic         clk = 1'b0;
    logic         resetn;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [151:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic [37:0]  es_to_ds_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    exe_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_to_ds_bus    (es_to_ds_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [70:0] ms;
        logic [37:0] ds;
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          t_acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   rand_ms = 0;
    bit   head_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r = 0;
        for (int i = 0; i < 12; i++) begin
            if (op[i]) begin
                case (i)
                    0:  r = r | (a + b);
                    1:  r = r | (a - b);
                    2:  r = r | (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    3:  r = r | ((a < b) ? 32'd1 : 32'd0);
                    4:  r = r | (a & b);
                    5:  r = r | ~(a | b);
                    6:  r = r | (a | b);
                    7:  r = r | (a ^ b);
                    8:  r = r | (a << b[4:0]);
                    9:  r = r | (a >> b[4:0]);
                    10: r = r | $unsigned($signed(a) >>> b[4:0]);
                    default: r = r | b;
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] div_ref(input logic [3:0] dop, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (dop[3] | dop[2]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b; r = a % b;
        end
        return (dop[3] | dop[1]) ? q : r;
    endfunction

    function automatic logic [151:0] mk(input logic [3:0] dop, input logic [11:0] aop, input logic rfm,
                                         input logic mwe, input logic gwe, input logic [4:0] dst,
                                         input logic [31:0] s1, input logic [31:0] s2,
                                         input logic [31:0] sd, input logic [31:0] pc);
        return {dop, aop, rfm, mwe, gwe, dst, s1, s2, sd, pc};
    endfunction

    function automatic exp_t model(input logic [151:0] bus);
        exp_t        e;
        logic [3:0]  dop = bus[151:148];
        logic [31:0] ar  = alu_ref(bus[147:136], bus[127:96], bus[95:64]);
        logic [31:0] res = ar;
        e.lat = 1;
`ifdef EXE_DIV_EN
        if (dop != 4'd0) begin
            res   = div_ref(dop, bus[127:96], bus[95:64]);
            e.lat = 34;
        end
`endif
        e.ms    = {bus[135], bus[133], bus[132:128], res, bus[31:0]};
        e.ds    = {bus[135], bus[133] ? bus[132:128] : 5'd0, res};
        e.en    = bus[135] | bus[134];
        e.we    = bus[134] ? 4'hF : 4'h0;
        e.addr  = ar;
        e.wdata = bus[63:32];
        e.t_acc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            head_seen = 0;
        end else if (es_to_ms_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", es_to_ms_valid, 0);
            end else begin
                if (!head_seen) begin
                    head_seen = 1;
                    chk("latency", cyc - sb[0].t_acc, sb[0].lat);
                end
                if (ms_allowin) begin
                    chk("es_to_ms_bus", es_to_ms_bus, sb[0].ms);
                    chk("es_to_ds_bus", es_to_ds_bus, sb[0].ds);
                    chk("sram_en", data_sram_en, sb[0].en);
                    chk("sram_we", data_sram_we, sb[0].we);
                    if (sb[0].en) chk("sram_addr", data_sram_addr, sb[0].addr);
                    if (sb[0].we != 0) chk("sram_wdata", data_sram_wdata, sb[0].wdata);
                    void'(sb.pop_front());
                    head_seen = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ms) ms_allowin = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [151:0] bus);
        exp_t e;
        int   n = 0;
        ds_to_es_bus   = bus;
        ds_to_es_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (es_allowin) break;
            n++;
            if (n > 400) begin
                chk("issue_accept", es_allowin, 1);
                ds_to_es_valid = 1'b0;
                return;
            end
            tick();
        end
        e = model(bus);
        e.t_acc = cyc;
        sb.push_back(e);
        tick();
        ds_to_es_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_es_to_ms_valid"}, es_to_ms_valid, 0);
        chk({tag, "_es_allowin"}, es_allowin, 1);
        chk({tag, "_sram_en"}, data_sram_en, 0);
        chk({tag, "_sram_we"}, data_sram_we, 0);
        chk({tag, "_hazard_hi"}, es_to_ds_bus[37:32], 0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return $urandom_range(0, 20);
            1: return 32'd0;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [151:0] b;
        logic [70:0]  held;
        int           n;
        resetn         = 1'b0;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        #3;
        check_reset_outputs("reset");
        #20 resetn = 1'b1;
        tick();

        // ADD 5 + 7 -> r3
        issue(mk(4'd0, 12'h001, 1'b0, 1'b0, 1'b1, 5'd3, 32'd5, 32'd7, 32'd0, 32'h1c00_0000));
        @(negedge clk);
        chk("add_hazard", es_to_ds_bus, {1'b0, 5'd3, 32'd12});
        tick();
        @(negedge clk);
        chk("add_one_cycle", es_to_ms_valid, 0);
        tick();

        // store held by ms for two cycles
        ms_allowin = 1'b0;
        issue(mk(4'd0, 12'h001, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1000, 32'd0, 32'hDEAD_BEEF, 32'h1c00_0004));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("store_stall_en", data_sram_en, 0);
            chk("store_stall_we", data_sram_we, 0);
            tick();
        end
        ms_allowin = 1'b1;
        @(negedge clk);
        chk("store_en", data_sram_en, 1);
        chk("store_we", data_sram_we, 4'hF);
        chk("store_addr", data_sram_addr, 32'h1000);
        chk("store_wdata", data_sram_wdata, 32'hDEAD_BEEF);
        tick();
        @(negedge clk);
        chk("store_once", data_sram_en, 0);
        tick();

        // boundary divides
        issue(mk(4'b1000, 12'h0, 1'b0, 1'b0, 1'b1, 5'd4, -32'd7, 32'd2, 32'd0, 32'h100));
        drain();
        issue(mk(4'b0100, 12'h0, 1'b0, 1'b0, 1'b1, 5'd5, -32'd7, 32'd2, 32'd0, 32'h104));
        issue(mk(4'b0010, 12'h0, 1'b0, 1'b0, 1'b1, 5'd6, 32'd100, 32'd0, 32'd0, 32'h108));
        issue(mk(4'b0001, 12'h0, 1'b0, 1'b0, 1'b1, 5'd7, 32'd100, 32'd0, 32'd0, 32'h10c));
        issue(mk(4'b1000, 12'h0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h110));
        drain();

        // result held while ms stalls, then an ADD enters on the handoff
        ms_allowin = 1'b0;
        b = mk(4'b1000, 12'h0, 1'b0, 1'b0, 1'b1, 5'd9, 32'd91, -32'd4, 32'd0, 32'h200);
        held = model(b).ms;
        issue(b);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (es_to_ms_valid) break;
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", es_to_ms_valid, 1);
            chk("stall_allowin", es_allowin, 0);
            chk("stall_bus", es_to_ms_bus, held);
            tick();
        end
        ms_allowin = 1'b1;
        issue(mk(4'd0, 12'h001, 1'b0, 1'b0, 1'b1, 5'd10, 32'd1, 32'd2, 32'd0, 32'h204));
        drain();

        // reset in the middle of an instruction aborts it
        ms_allowin = 1'b0;
        issue(mk(4'b1000, 12'h0, 1'b0, 1'b0, 1'b1, 5'd11, 32'd1000, 32'd3, 32'd0, 32'h300));
        repeat (11) tick();
        #1 resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        #6 resetn = 1'b1;
        ms_allowin = 1'b1;
        tick();
        issue(mk(4'd0, 12'h001, 1'b0, 1'b0, 1'b1, 5'd12, 32'd40, 32'd2, 32'd0, 32'h304));
        drain();

        // randomized traffic with random ms back-pressure
        rand_ms = 1;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] dop = 4'd0;
            logic rfm = 1'b0, mwe = 1'b0;
            if ($urandom_range(0, 3) == 0) dop = 4'(1 << $urandom_range(0, 3));
            else if ($urandom_range(0, 2) == 0) begin
                rfm = $urandom_range(0, 1);
                mwe = !rfm;
            end
            issue(mk(dop, 12'(1 << $urandom_range(0, 11)), rfm, mwe, 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)), rnd_val(), rnd_val(), $urandom, $urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_ms = 0;
        ms_allowin = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
